// File: rtl/comb_inverse.sv
// Inverse comb stage: rebuilds I/Q samples from comb-filtered input using a D-deep
// history and leaky feedback. Define COMB_INVERSE_SAT_EN to clamp instead of wrap.
module comb_inverse #(
   parameter int BIT_WIDTH  = 16,
   parameter int DELAY_LOG2 = 3
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic                                      strobe_in,
   input  logic signed [BIT_WIDTH+DELAY_LOG2-1:0]    i_in,
   input  logic signed [BIT_WIDTH+DELAY_LOG2-1:0]    q_in,
   output logic                                      strobe_out,
   output logic signed [BIT_WIDTH-1:0]               i_out,
   output logic signed [BIT_WIDTH-1:0]               q_out,
   output logic                                      primed
);

   localparam int W  = BIT_WIDTH;
   localparam int L  = DELAY_LOG2;
   localparam int D  = 1 << L;
   localparam int IW = W + L;
   localparam int SW = W + L + 1;
   localparam logic [L:0] FILL_FULL = D[L:0];

   logic signed [IW-1:0] hist_i [D];
   logic signed [IW-1:0] hist_q [D];

   logic [L-1:0]         ptr_q, ptr_d;
   logic [L:0]           fill_q, fill_d;
   logic                 vld_q;
   logic signed [SW-1:0] sumi_q, sumi_d;
   logic signed [SW-1:0] sumq_q, sumq_d;
   logic                 stb_q;
   logic signed [W-1:0]  iout_q, qout_q;
   logic signed [W-1:0]  iconv, qconv;
   logic signed [IW-1:0] h_i, h_q;

   function automatic logic signed [SW-1:0] ext(input logic signed [IW-1:0] x);
      return {x[IW-1], x};
   endfunction

   // Until the history has wrapped once, ptr always points at an unwritten slot.
   assign primed = (fill_q == FILL_FULL);
   assign h_i    = primed ? hist_i[ptr_q] : '0;
   assign h_q    = primed ? hist_q[ptr_q] : '0;

   always_comb begin
      ptr_d  = ptr_q;
      fill_d = fill_q;
      sumi_d = ext(i_in) + ext(h_i) - ext(h_i >>> L);
      sumq_d = ext(q_in) + ext(h_q) - ext(h_q >>> L);
      if (strobe_in) begin
         ptr_d = ptr_q + L'(1);
         if (fill_q != FILL_FULL) begin
            fill_d = fill_q + (L+1)'(1);
         end
      end
   end

`ifdef COMB_INVERSE_SAT_EN
   function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] s);
      if ((&s[SW-1:W-1]) || !(|s[SW-1:W-1])) begin
         return s[W-1:0];
      end
      return s[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   endfunction

   assign iconv = sat(sumi_q);
   assign qconv = sat(sumq_q);
`else
   logic unused_sum_hi;
   assign unused_sum_hi = ^{sumi_q[SW-1:W], sumq_q[SW-1:W]};
   assign iconv = sumi_q[W-1:0];
   assign qconv = sumq_q[W-1:0];
`endif

   always_ff @(posedge clock) begin
      if (strobe_in) begin
         hist_i[ptr_q] <= i_in;
         hist_q[ptr_q] <= q_in;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q  <= '0;
         fill_q <= '0;
         vld_q  <= 1'b0;
         sumi_q <= '0;
         sumq_q <= '0;
         stb_q  <= 1'b0;
         iout_q <= '0;
         qout_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         fill_q <= fill_d;
         vld_q  <= strobe_in;
         stb_q  <= vld_q;
         if (strobe_in) begin
            sumi_q <= sumi_d;
            sumq_q <= sumq_d;
         end
         if (vld_q) begin
            iout_q <= iconv;
            qout_q <= qconv;
         end
      end
   end

   assign strobe_out = stb_q;
   assign i_out      = iout_q;
   assign q_out      = qout_q;

endmodule

// File: doc/comb_inverse.md
COMB_INVERSE -- requirements
Module: comb_inverse

Interface
REQ-001: Parameter BIT_WIDTH, default 16, SHALL set the output sample width W.
REQ-002: Parameter DELAY_LOG2, default 3, SHALL set L; delay depth D = 2^L and feedback shift = L.
REQ-003: clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: reset  input  1  SHALL be asynchronous, active-high.
REQ-005: strobe_in  input  1  SHALL qualify i_in/q_in as one new sample.
REQ-006: i_in, q_in  input  W+L  SHALL be the signed two's-complement comb-filtered I/Q samples.
REQ-007: strobe_out  output  1  SHALL pulse high for one cycle per reconstructed sample.
REQ-008: i_out, q_out  output  W  SHALL be the signed reconstructed I/Q samples.
REQ-009: primed  output  1  SHALL be high once D samples have been written to the history.

Function
REQ-010: Each channel SHALL hold a D-entry history and a shared L-bit write pointer that wraps D-1 -> 0.
REQ-011: On a cycle with strobe_in high, h SHALL be history[ptr] if that entry has been written since reset, else 0.
REQ-012: Stage 1 SHALL compute sum = in + h - (h >>> L), sign-extended to W+L+1 bits, with arithmetic (floor) shift.
REQ-013: On the same edge, in SHALL be written to history[ptr] and ptr SHALL increment.
REQ-014: Stage 2 SHALL convert sum to W bits per REQ-024/025 and register it onto i_out/q_out.
REQ-015: strobe_out SHALL assert exactly 2 clock edges after the edge that sampled strobe_in high.
REQ-016: Throughput SHALL be one sample per cycle; back-to-back strobes SHALL need no stalls.
REQ-017: Without strobe_in, history, ptr and fill count SHALL not change; i_out/q_out SHALL hold; strobe_out SHALL be low.
REQ-018: Fill counter SHALL count strobes and saturate at D; primed SHALL assert on the edge writing the D-th sample and stay high until reset.
REQ-019: I and Q SHALL use identical, independent arithmetic.

Reset
REQ-020: Reset assertion SHALL immediately clear ptr, fill count, pipeline valid bits, strobe_out, i_out, q_out and primed to 0.
REQ-021: In-flight samples at reset SHALL be discarded; no strobe_out SHALL follow from them.
REQ-022: History contents need not be cleared; REQ-011 masking SHALL make stale entries invisible.
REQ-023: After deassertion, behaviour SHALL be identical to power-on.

Configuration
REQ-024: With COMB_INVERSE_SAT_EN defined, sum SHALL clamp to [-2^(W-1), 2^(W-1)-1].
REQ-025: Without COMB_INVERSE_SAT_EN, the low W bits of sum SHALL be output (wrap); latency unchanged.

Verification (W=16, L=3, D=8)
REQ-026: Reset; strobe i_in=100, then zeros every cycle -> i_out 100 on 1st strobe_out, 0 on 2nd-8th, 88 on 9th, primed high from 8th strobe.
REQ-027: Same with i_in=-100 -> 9th output -87 (floor shift -13).
REQ-028: Single strobe i_in=40000 -> i_out 32767 with COMB_INVERSE_SAT_EN, -25536 without.
REQ-029: Strobes every 3rd cycle, 10 samples -> strobe_out exactly 2 cycles after each, 10 pulses, ptr advances only on strobes.
REQ-030: Assert reset with 2 samples in pipeline -> strobe_out, i_out, q_out, primed 0 immediately, no late pulses; REQ-026 then passes unchanged.
REQ-031: Feed a reference comb model's output of a random 1000-sample I/Q stream -> i_out/q_out match original input bit-exactly after the 2-cycle latency.
